// File: rtl/dsp_chiplet_pkg.sv
// Shared defaults and the complex-sample type for the chiplet DSP blocks.
package dsp_chiplet_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 12;
    localparam int unsigned DEF_N          = 16;
    localparam int unsigned DEF_TIMEOUT    = 64;
    localparam int unsigned ADDR_W         = $clog2(DEF_N);

    // One complex sample as stored in the frame store: real in the upper half.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] re;
        logic [DEF_DATA_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one registered read port.
// Only the read data register is reset; the array keeps its contents.
module frame_bank_ram #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned N          = 16,
    parameter int unsigned AW         = $clog2(N)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_we,
    input  logic                    i_wr_bank,
    input  logic [AW-1:0]           i_wr_idx,
    input  logic [2*DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_re,
    input  logic                    i_rd_bank,
    input  logic [AW-1:0]           i_rd_idx,
    output logic [2*DATA_WIDTH-1:0] o_rd_data
);

    logic [2*DATA_WIDTH-1:0] r_mem [2*N];
    logic [2*DATA_WIDTH-1:0] r_rd_data;

    // Sample write into the selected bank/slot.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_wr_bank, i_wr_idx}] <= i_wr_data;
        end
    end

    // Registered read; data holds when no read is requested.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_idx}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dma_rx_sink.sv
// Host-side DMA receiver: fills a ping-pong frame store with complex samples,
// exposes completed frames for addressed reads and drops stalled partial frames.
module dma_rx_sink
    import dsp_chiplet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned N          = DEF_N,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dma_valid,
    input  logic [DATA_WIDTH-1:0] dma_real,
    input  logic [DATA_WIDTH-1:0] dma_imag,
    output logic                  dma_ack,
    output logic                  frame_ready,
    input  logic                  rd_en,
    input  logic [$clog2(N)-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_real,
    output logic [DATA_WIDTH-1:0] rd_imag,
    output logic                  rd_valid,
    input  logic                  frame_release,
    output logic [15:0]           frame_count,
    output logic                  timeout_err
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic [1:0]              r_bank_full;
    logic [AW-1:0]           r_wr_idx;
    logic [IW-1:0]           r_idle_cnt;
    logic [15:0]             r_frame_count;
    logic                    r_dma_ack;
    logic                    r_timeout_err;
    logic                    r_rd_valid;

    logic                    w_transfer;
    logic                    w_complete;
    logic                    w_release;
    logic                    w_rd_fire;
    logic                    w_idle_expire;
    logic [1:0]              w_bank_full_nxt;
    logic                    w_wr_bank_nxt;
    logic [2*DATA_WIDTH-1:0] w_rd_data;

    assign w_transfer    = dma_valid & r_dma_ack;
    assign w_complete    = w_transfer & (r_wr_idx == AW'(N - 1));
    assign w_release     = frame_release & r_bank_full[r_rd_bank];
    assign w_rd_fire     = rd_en & r_bank_full[r_rd_bank];
    assign w_idle_expire = !w_transfer && (r_wr_idx != '0) && (r_idle_cnt == IW'(TIMEOUT - 1));

    // Next bank occupancy: release and completion always hit different banks.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_release) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_complete) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
        w_wr_bank_nxt = r_wr_bank ^ w_complete;
    end

    // Bank pointers, occupancy flags and the registered accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_dma_ack   <= 1'b0;
        end else begin
            r_wr_bank   <= w_wr_bank_nxt;
            r_bank_full <= w_bank_full_nxt;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            // Accept only if the bank we will write next has room.
            r_dma_ack <= !w_bank_full_nxt[w_wr_bank_nxt];
        end
    end

    // Write index: advances per transfer, wraps on completion, clears on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_idx <= '0;
        end else if (w_transfer) begin
            r_wr_idx <= w_complete ? '0 : r_wr_idx + 1'b1;
        end else if (w_idle_expire) begin
            r_wr_idx <= '0;
        end
    end

    // Idle counter for stalled partial frames and the drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_idle_expire;
            if (w_transfer || (r_wr_idx == '0) || w_idle_expire) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    // Completed-frame counter with natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_complete) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    // Read-valid tracks the one-cycle RAM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
        end
    end

    frame_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .AW         (AW)
    ) u_ram (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_we      (w_transfer),
        .i_wr_bank (r_wr_bank),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data ({dma_real, dma_imag}),
        .i_re      (w_rd_fire),
        .i_rd_bank (r_rd_bank),
        .i_rd_idx  (rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign dma_ack     = r_dma_ack;
    assign frame_ready = r_bank_full[r_rd_bank];
    assign rd_real     = w_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign rd_imag     = w_rd_data[DATA_WIDTH-1:0];
    assign rd_valid    = r_rd_valid;
    assign frame_count = r_frame_count;
    assign timeout_err = r_timeout_err;

endmodule
